// File: rtl/irq_controller_pkg.sv
// ---------------------------------------------------------------------------
// irq_controller_pkg
//   Shared definitions for the interrupt controller and its bench:
//   FSM state encoding, cause codes, WAIT_K timeout, HOLD length,
//   the control word passed to the pending bank, and small helpers.
// ---------------------------------------------------------------------------
package irq_controller_pkg;

  localparam int unsigned NUM_SRC = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT_K = 3'd2,
    ST_IN_K   = 3'd3,
    ST_HOLD   = 3'd4
  } irq_state_e;

  // Cause codes: {1'b0, source index} for interrupts, EXC_UNDEF for exceptions
  localparam logic [2:0] CAUSE_TIMER   = 3'b000;
  localparam logic [2:0] CAUSE_UART_RX = 3'b001;
  localparam logic [2:0] CAUSE_UART_TX = 3'b010;
  localparam logic [2:0] CAUSE_EXT     = 3'b011;
  localparam logic [2:0] EXC_UNDEF     = 3'b100;

  // Cycles WAIT_K waits for kernel entry, and cycles spent in HOLD
  localparam int unsigned WAIT_K_TIMEOUT = 8;
  localparam int unsigned HOLD_CYCLES    = 2;

  localparam int unsigned WAIT_CNT_W = $clog2(WAIT_K_TIMEOUT);
  localparam int unsigned HOLD_CNT_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  // FSM -> pending bank: clear the bit being taken, or put it back on timeout
  typedef struct packed {
    logic       take;
    logic [1:0] take_idx;
    logic       restore;
    logic [1:0] restore_idx;
  } bank_ctrl_t;

  // Index of the lowest set bit; 0 when the vector is empty
  function automatic logic [1:0] lowest_set_idx(input logic [NUM_SRC-1:0] vec);
    logic [1:0] idx;
    logic       found;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (vec[i] && !found) begin
        idx   = i[1:0];
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [2:0] src_cause(input logic [1:0] idx);
    case (idx)
      2'd0:    return CAUSE_TIMER;
      2'd1:    return CAUSE_UART_RX;
      2'd2:    return CAUSE_UART_TX;
      default: return CAUSE_EXT;
    endcase
  endfunction

endpackage

// File: rtl/irq_controller_pending_bank.sv
// ---------------------------------------------------------------------------
// irq_pending_bank
//   Rising-edge detector on the level interrupt sources, sticky pending
//   register and lowest-index priority encoder over (pending & mask).
//
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_irq_src        level interrupt sources
//   i_clr_wr/_wdata  write-1-to-clear of pending bits
//   i_mask           current enable mask
//   i_ctrl           take (clear) / restore (set) of one bit from the FSM
//   o_pending        sticky pending bits
//   o_any_ready      at least one pending bit is enabled
//   o_sel_idx        lowest enabled pending index
// ---------------------------------------------------------------------------
module irq_pending_bank
  import irq_controller_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_SRC-1:0] i_irq_src,
  input  logic               i_clr_wr,
  input  logic [NUM_SRC-1:0] i_clr_wdata,
  input  logic [NUM_SRC-1:0] i_mask,
  input  bank_ctrl_t         i_ctrl,
  output logic [NUM_SRC-1:0] o_pending,
  output logic               o_any_ready,
  output logic [1:0]         o_sel_idx
);

  logic [NUM_SRC-1:0] r_src_q;
  logic [NUM_SRC-1:0] r_pending;
  logic [NUM_SRC-1:0] w_rise;
  logic [NUM_SRC-1:0] w_clr;
  logic [NUM_SRC-1:0] w_take;
  logic [NUM_SRC-1:0] w_restore;
  logic [NUM_SRC-1:0] w_ready;

  assign w_rise = i_irq_src & ~r_src_q;

  always_comb begin
    w_clr     = i_clr_wr ? i_clr_wdata : '0;
    w_take    = '0;
    w_restore = '0;
    if (i_ctrl.take)    w_take[i_ctrl.take_idx]       = 1'b1;
    if (i_ctrl.restore) w_restore[i_ctrl.restore_idx] = 1'b1;
  end

  // Sets (new edge or restore) are OR-ed in after clears, so a set wins
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_src_q   <= '0;
      r_pending <= '0;
    end else begin
      r_src_q   <= i_irq_src;
      r_pending <= (r_pending & ~(w_clr | w_take)) | w_rise | w_restore;
    end
  end

  assign w_ready     = r_pending & i_mask;
  assign o_pending   = r_pending;
  assign o_any_ready = |w_ready;
  assign o_sel_idx   = lowest_set_idx(w_ready);

endmodule

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Interrupt/exception sequencer for a CPU with a PC[31] kernel flag.
//   Issues one interrupt at a time, waits for kernel entry (with timeout),
//   waits for the return, then holds off so a user instruction retires
//   between handlers. Undefined-instruction exceptions are signalled
//   combinationally while in user-visible states.
//
//   clk          system clock
//   reset        asynchronous active-low reset
//   irq_src      level sources: 0 timer, 1 UART-rx, 2 UART-tx, 3 external
//   mask_wr      enable-mask write strobe, mask_wdata new mask
//   clr_wr       pending write-1-to-clear strobe, clr_wdata bits to clear
//   pchigh       current kernel-mode flag (PC[31])
//   stall        no instruction retires this cycle
//   undef_instr  current instruction is unimplemented
//   Interrupt    interrupt-entry request (one cycle)
//   Exception    exception-entry request (combinational)
//   cause        interrupt source code or EXC_UNDEF
//   pending      sticky pending bits
//   mask         current enable mask
//   busy         FSM is outside IDLE/HOLD
// ---------------------------------------------------------------------------
module irq_controller
  import irq_controller_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] irq_src,
  input  logic       mask_wr,
  input  logic [3:0] mask_wdata,
  input  logic       clr_wr,
  input  logic [3:0] clr_wdata,
  input  logic       pchigh,
  input  logic       stall,
  input  logic       undef_instr,
  output logic       Interrupt,
  output logic       Exception,
  output logic [2:0] cause,
  output logic [3:0] pending,
  output logic [3:0] mask,
  output logic       busy
);

  irq_state_e            r_state;
  irq_state_e            w_state_nxt;
  logic [WAIT_CNT_W-1:0] r_wait_cnt;
  logic [HOLD_CNT_W-1:0] r_hold_cnt;
  logic [3:0]            r_mask;
  logic [2:0]            r_cause;
  logic                  r_interrupt;

  logic                  w_any_ready;
  logic [1:0]            w_sel_idx;
  logic [3:0]            w_pending;
  logic                  w_user_window;
  logic                  w_issue;
  logic                  w_timeout;
  logic                  w_hold_done;
  bank_ctrl_t            w_bank_ctrl;

  irq_pending_bank u_bank (
    .i_clk       (clk),
    .i_rst_n     (reset),
    .i_irq_src   (irq_src),
    .i_clr_wr    (clr_wr),
    .i_clr_wdata (clr_wdata),
    .i_mask      (r_mask),
    .i_ctrl      (w_bank_ctrl),
    .o_pending   (w_pending),
    .o_any_ready (w_any_ready),
    .o_sel_idx   (w_sel_idx)
  );

  assign w_user_window = (r_state == ST_IDLE) || (r_state == ST_HOLD);

  // An undefined instruction blocks the issue, leaving the interrupt pending
  assign w_issue = (r_state == ST_IDLE) && w_any_ready && !pchigh && !stall && !undef_instr;

  assign w_timeout = (r_state == ST_WAIT_K) && !pchigh &&
                     (r_wait_cnt == WAIT_CNT_W'(WAIT_K_TIMEOUT - 1));

  assign w_hold_done = (r_hold_cnt == HOLD_CNT_W'(HOLD_CYCLES - 1));

  // r_cause[1:0] still holds the taken source index during WAIT_K
  always_comb begin
    w_bank_ctrl             = '0;
    w_bank_ctrl.take        = w_issue;
    w_bank_ctrl.take_idx    = w_sel_idx;
    w_bank_ctrl.restore     = w_timeout;
    w_bank_ctrl.restore_idx = r_cause[1:0];
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_issue) w_state_nxt = ST_ISSUE;
      ST_ISSUE:  w_state_nxt = ST_WAIT_K;
      ST_WAIT_K: begin
        if (pchigh)         w_state_nxt = ST_IN_K;
        else if (w_timeout) w_state_nxt = ST_IDLE;
      end
      ST_IN_K:   if (!pchigh) w_state_nxt = ST_HOLD;
      ST_HOLD:   if (w_hold_done) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Counters free-run inside their state and clear elsewhere; ISSUE always
  // precedes WAIT_K and IN_K always precedes HOLD, so both start at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= '0;
      r_hold_cnt  <= '0;
      r_mask      <= '0;
      r_cause     <= '0;
      r_interrupt <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_interrupt <= w_issue;
      r_wait_cnt  <= (r_state == ST_WAIT_K) ? r_wait_cnt + 1'b1 : '0;
      r_hold_cnt  <= (r_state == ST_HOLD)   ? r_hold_cnt + 1'b1 : '0;
      if (mask_wr) r_mask  <= mask_wdata;
      if (w_issue) r_cause <= src_cause(w_sel_idx);
    end
  end

  assign Interrupt = r_interrupt;
  assign Exception = w_user_window & undef_instr & ~pchigh;
  assign cause     = Exception ? EXC_UNDEF : r_cause;
  assign pending   = w_pending;
  assign mask      = r_mask;
  assign busy      = !w_user_window;

endmodule

// File: doc/irq_controller.md
IRQ_CONTROLLER -- requirements
Module: irq_controller

Interface
REQ-001 The block SHALL have the following ports, listed as name, direction, width and meaning.
REQ-002 clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 irq_src  in  4  level interrupt sources: 0 timer, 1 UART-rx, 2 UART-tx, 3 external.
REQ-005 mask_wr  in  1  write strobe for the enable mask.
REQ-006 mask_wdata  in  4  new enable mask; 1 means enabled.
REQ-007 clr_wr  in  1  write-1-to-clear strobe for the pending bits.
REQ-008 clr_wdata  in  4  pending bits to clear.
REQ-009 pchigh  in  1  PC[31], the current kernel-mode flag.
REQ-010 stall  in  1  no instruction retires this cycle; an interrupt must not be issued.
REQ-011 undef_instr  in  1  the decoder flags the current instruction as unimplemented.
REQ-012 Interrupt  out  1  interrupt-entry request to the CPU control unit.
REQ-013 Exception  out  1  exception-entry request to the CPU control unit.
REQ-014 cause  out  3  {1'b0, src index} for an interrupt; 3'b100 for an exception.
REQ-015 pending  out  4  sticky pending bits.
REQ-016 mask  out  4  current enable mask.
REQ-017 busy  out  1  asserted whenever the FSM is not in IDLE or HOLD.

Function
REQ-018 A rising edge on irq_src[i] SHALL set pending[i] one cycle after the edge is sampled; the edge is detected against a registered copy of irq_src.
REQ-019 If clr_wr clears a pending bit in the same cycle that a new edge sets it, pending SHALL end up set (set wins).
REQ-020 mask_wr SHALL update mask on the next clock edge.
REQ-021 The FSM SHALL have the states IDLE, ISSUE, WAIT_K, IN_K and HOLD.
REQ-022 IDLE -> ISSUE SHALL occur when (pending & mask) != 0, pchigh=0, stall=0 and undef_instr=0.
REQ-023 Entering ISSUE SHALL latch cause, choosing the lowest set index of (pending & mask), and SHALL clear that pending bit.
REQ-024 ISSUE SHALL last exactly 1 cycle with Interrupt=1, then move to WAIT_K.
REQ-025 Interrupt SHALL be registered and asserted only while in ISSUE.
REQ-026 WAIT_K -> IN_K SHALL occur when pchigh=1.
REQ-027 If pchigh does not go to 1 within 8 cycles of entering WAIT_K, WAIT_K SHALL move to IDLE and the taken pending bit SHALL be set again.
REQ-028 IN_K -> HOLD SHALL occur when pchigh=0 (return from kernel).
REQ-029 HOLD SHALL last 2 cycles and then move to IDLE, so that at least one user instruction retires between handlers.
REQ-030 Exception SHALL equal undef_instr & ~pchigh while in IDLE or HOLD, combinationally and without waiting for a clock edge.
REQ-031 When Exception is asserted, cause SHALL read 3'b100 in that same cycle.
REQ-032 An exception SHALL take precedence over an interrupt in the same cycle; the interrupt stays pending.
REQ-033 No Interrupt or Exception SHALL be asserted while pchigh=1, which means no nesting.
REQ-034 A masked pending bit SHALL stay pending and SHALL fire once it is unmasked.

Reset
REQ-035 While reset=0, the block SHALL be in IDLE with pending=0, mask=4'b0000, cause=0, Interrupt=0, busy=0, the edge register at 0 and all counters at 0.
REQ-036 If reset is asserted mid-handshake, all state SHALL be discarded and no pending bit is restored.

Structure
REQ-037 The state encodings, the cause codes (including EXC_UNDEF = 3'b100), the WAIT_K timeout of 8 and the HOLD length of 2 SHALL be defined in a shared package used by the control unit and its bench.
REQ-038 The edge detector, pending register and priority encoder SHALL be one sub-module, irq_pending_bank; the FSM and counters SHALL stay in irq_controller.

Verification
REQ-039 Bench case: mask=4'b1111, then irq_src[2] rises with pchigh=0 -> pending=4'b0100 the next cycle, then Interrupt=1 for one cycle with cause=3'b010, and pending=0.
REQ-040 Bench case: irq_src[1] and irq_src[3] rise together -> cause=3'b001 is served first; after pchigh 0->1->0 plus 2 HOLD cycles, cause=3'b011 is issued.
REQ-041 Bench case: undef_instr=1 and pending[0]=1 in the same IDLE cycle -> Exception=1 with cause=3'b100, Interrupt=0, and pending[0] still 1.
REQ-042 Bench case: ISSUE with pchigh held at 0 for 8 cycles -> the FSM returns to IDLE with the pending bit restored.
REQ-043 Bench case: mask=0 with pending=4'b0001, then mask_wr with 4'b0001 -> Interrupt is issued within 2 cycles.
REQ-044 Bench case: reset asserted during IN_K -> IDLE immediately, with pending=0 and mask=0.
